// File: rtl/seq_det_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seq_det_pkg                                                      |
// | State encoding and step/output functions of the w-seq detector.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package seq_det_pkg;

  typedef enum logic [2:0] {
    A = 3'd0,
    B = 3'd1,
    C = 3'd2,
    D = 3'd3,
    E = 3'd4,
    F = 3'd5
  } state_t;

  // Unused codes 6/7 fall back to A so a corrupted context self-recovers.
  function automatic state_t step(input state_t s, input logic w);
    state_t n;
    case (s)
      A:       n = w ? B : A;
      B:       n = w ? C : D;
      C:       n = w ? E : D;
      D:       n = w ? F : A;
      E:       n = w ? E : D;
      F:       n = w ? C : D;
      default: n = A;
    endcase
    return n;
  endfunction

  function automatic logic zout(input state_t s);
    return (s == E) || (s == F);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arbiter                                                       |
// | Round-robin arbiter: first requester at or after ptr, wrapping.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module rr_arbiter #(
  parameter int N    = 4,
  parameter int CH_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic            en,
  input  logic [CH_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [CH_W-1:0] gnt_idx,
  output logic            any
);

  logic [N-1:0]    w_hi;
  logic            w_found;
  logic [CH_W-1:0] w_idx;

  // Requesters at or above ptr win first; otherwise wrap to the lowest one.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      w_hi[k] = req[k] && ((CH_W+1)'(k) >= {1'b0, ptr});
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && w_hi[k]) begin
        w_found = 1'b1;
        w_idx   = CH_W'(k);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[k]) begin
        w_found = 1'b1;
        w_idx   = CH_W'(k);
      end
    end
  end

  always_comb begin
    any     = en & w_found;
    gnt_idx = w_idx;
    for (int k = 0; k < N; k++) begin
      gnt[k] = any && (w_idx == CH_W'(k));
    end
  end

endmodule
`default_nettype wire

// File: rtl/shared_seq_detect_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | shared_seq_detect_sched                                          |
// | One w-sequence detector time-shared across N channel contexts.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module shared_seq_detect_sched
  import seq_det_pkg::*;
#(
  parameter int N    = 4,
  parameter int CH_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_w,
  output logic [N-1:0]    in_ready,
  input  logic [N-1:0]    ch_clear,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic            out_z,
  output logic [N-1:0]    ctx_z
);

  state_t          r_ctx     [N];
  state_t          w_ctx_nxt [N];
  state_t          w_step;
  logic [N-1:0]    w_elig;
  logic [N-1:0]    w_gnt;
  logic [CH_W-1:0] w_gnt_idx;
  logic            w_any;
  logic            w_stall;
  logic [CH_W-1:0] r_ptr;
  logic            r_out_valid;
  logic [CH_W-1:0] r_out_ch;
  logic            r_out_z;

  // A cleared channel is never eligible, so clear and step never collide.
  assign w_elig  = in_valid & ~ch_clear;
  assign w_stall = r_out_valid & ~out_ready;

  rr_arbiter #(
    .N    (N),
    .CH_W (CH_W)
  ) u_arb (
    .req     (w_elig),
    .en      (~w_stall),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  assign in_ready = w_gnt;

  // The single shared detector step, applied to the granted context.
  always_comb begin
    w_step = step(r_ctx[w_gnt_idx], in_w[w_gnt_idx]);
  end

  // Context next-state
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_ctx_nxt[i] = r_ctx[i];
      if (ch_clear[i]) begin
        w_ctx_nxt[i] = A;
      end else if (w_gnt[i]) begin
        w_ctx_nxt[i] = w_step;
      end
    end
  end

  // Context state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset) begin
        r_ctx[i] <= A;
      end else begin
        r_ctx[i] <= w_ctx_nxt[i];
      end
    end
  end

  // Per-channel Moore output, registered through the context itself.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctx_z[i] = zout(r_ctx[i]);
    end
  end

  // Result register and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_ch    <= '0;
      r_out_z     <= 1'b0;
    end else if (w_any) begin
      r_out_valid <= 1'b1;
      r_out_ch    <= w_gnt_idx;
      r_out_z     <= zout(w_step);
      r_ptr       <= (w_gnt_idx == CH_W'(N - 1)) ? '0 : w_gnt_idx + CH_W'(1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_ch    = r_out_ch;
  assign out_z     = r_out_z;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (reset)
    $onehot0(in_ready));
  a_no_gnt_stall : assert property (@(posedge clk) disable iff (reset)
    w_stall |-> (in_ready == '0));
  a_no_gnt_clear : assert property (@(posedge clk) disable iff (reset)
    (in_ready & ch_clear) == '0);

endmodule
`default_nettype wire

// File: tb/tb_shared_seq_detect_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_shared_seq_detect_sched                                       |
// | Vector table plus scoreboard bench for the shared detector.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_shared_seq_detect_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in_valid = '0;
  logic [3:0] in_w = '0;
  logic [3:0] ch_clear = '0;
  logic [3:0] in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [1:0] out_ch;
  logic       out_z;
  logic [3:0] ctx_z;

  always #5 clk = ~clk;

  shared_seq_detect_sched #(.N(N), .CH_W(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_w      (in_w),
    .in_ready  (in_ready),
    .ch_clear  (ch_clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_z     (out_z),
    .ctx_z     (ctx_z)
  );

  typedef struct {
    logic [1:0] ch;
    logic       z;
  } exp_t;

  typedef struct {
    logic [3:0] vld;
    logic [3:0] w;
    logic [3:0] clr;
    logic       ordy;
    logic [3:0] exp_rdy;
    logic       exp_z;
  } vec_t;

  exp_t       sb [$];
  vec_t       tbl [15];
  int         n_checks = 0;
  int         n_errors = 0;
  int         m_ctx [4];
  int         m_ptr;
  logic       m_ov;
  logic [1:0] m_och;
  logic       m_oz;
  int         nxt_tab [8][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic mz(input int s);
    return (s == 4) || (s == 5);
  endfunction

  function automatic logic [3:0] model_ctxz();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mz(m_ctx[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ctx[i] = 0;
    m_ptr = 0;
    m_ov  = 1'b0;
    m_och = 2'd0;
    m_oz  = 1'b0;
    sb.delete();
  endtask

  // One clock: drive at negedge, check grant before the edge, results after.
  task automatic cycle(input logic [3:0] vld, input logic [3:0] w, input logic [3:0] clr,
                       input logic ordy, output logic [3:0] rdy_seen);
    logic       stall;
    logic [3:0] elig;
    logic [3:0] exp_rdy;
    int         g;
    int         nx;
    int         c;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    in_valid  = vld;
    in_w      = w;
    ch_clear  = clr;
    out_ready = ordy;
    #1;
    stall   = m_ov & ~ordy;
    elig    = vld & ~clr;
    exp_rdy = '0;
    g       = -1;
    nx      = 0;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && elig[c[1:0]]) g = c;
      end
    end
    if (g >= 0) begin
      exp_rdy[g[1:0]] = 1'b1;
      nx   = nxt_tab[m_ctx[g]][w[g[1:0]]];
      e.ch = g[1:0];
      e.z  = mz(nx);
      sb.push_back(e);
    end
    rdy_seen = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) if (clr[i]) m_ctx[i] = 0;
    if (g >= 0) begin
      m_ctx[g] = nx;
      m_ov     = 1'b1;
      m_och    = g[1:0];
      m_oz     = mz(nx);
      m_ptr    = (g + 1) % N;
    end else if (ordy) begin
      m_ov = 1'b0;
    end
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    if (g >= 0) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        got = sb.pop_front();
        chk("out_result", 32'({out_ch, out_z}), 32'({got.ch, got.z}));
      end
    end else if (m_ov) begin
      chk("out_hold", 32'({out_ch, out_z}), 32'({m_och, m_oz}));
    end
    chk("ctx_z", 32'(ctx_z), 32'(model_ctxz()));
  endtask

  task automatic do_reset(input logic [3:0] vld);
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = vld;
    in_w      = '1;
    ch_clear  = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ch_z", 32'({out_ch, out_z}), 32'd0);
    chk("rst_ctx_z", 32'(ctx_z), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seen;
    nxt_tab[0] = '{0, 1};
    nxt_tab[1] = '{3, 2};
    nxt_tab[2] = '{3, 4};
    nxt_tab[3] = '{0, 5};
    nxt_tab[4] = '{3, 4};
    nxt_tab[5] = '{3, 2};
    nxt_tab[6] = '{0, 0};
    nxt_tab[7] = '{0, 0};

    // Channel 0 alone: w=1,1,1,0,1 walks B,C,E,D,F.
    tbl[0]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0};
    tbl[1]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0};
    tbl[2]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1};
    tbl[3]  = '{4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};
    tbl[4]  = '{4'b0001, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1};
    // Requesters 1 and 3 alternate; pointer wraps 3 -> 0.
    tbl[5]  = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b0};
    tbl[6]  = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b0};
    tbl[7]  = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b0};
    tbl[8]  = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b0};
    tbl[9]  = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b0010, 1'b1};
    tbl[10] = '{4'b1010, 4'b1010, 4'b0000, 1'b1, 4'b1000, 1'b1};
    // Three stalled cycles, then release grants channel 0 (F,w=0 -> D).
    tbl[11] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[12] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[13] = '{4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[14] = '{4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0001, 1'b0};

    do_reset(4'b0000);

    for (int i = 0; i < 15; i++) begin
      cycle(tbl[i].vld, tbl[i].w, tbl[i].clr, tbl[i].ordy, seen);
      chk($sformatf("tbl%0d_rdy", i), 32'(seen), 32'(tbl[i].exp_rdy));
      if (tbl[i].exp_rdy != 4'b0000) begin
        chk($sformatf("tbl%0d_z", i), 32'(out_z), 32'(tbl[i].exp_z));
      end
      if (i == 4) chk("ch0_ends_in_F", 32'(ctx_z[0]), 32'd1);
    end

    // Drive channel 2 to E, then clear it while it still requests.
    for (int k = 0; k < 3; k++) cycle(4'b0100, 4'b0100, 4'b0000, 1'b1, seen);
    chk("ch2_in_E", 32'(ctx_z[2]), 32'd1);
    cycle(4'b0100, 4'b0100, 4'b0100, 1'b1, seen);
    chk("clear_no_grant", 32'(seen), 32'd0);
    chk("clear_ctx_z", 32'(ctx_z[2]), 32'd0);
    cycle(4'b0100, 4'b0100, 4'b0000, 1'b1, seen);
    chk("after_clear_ch", 32'(out_ch), 32'd2);
    chk("after_clear_z", 32'(out_z), 32'd0);

    // Reset while a result is pending and contexts sit in E/F.
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    do_reset(4'b1111);
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 4'b1111, 4'b0000, 1'b1, seen);
      chk($sformatf("rr%0d_grant", k), 32'(seen), 32'(4'b0001 << (k % 4)));
      chk($sformatf("rr%0d_out_ch", k), 32'(out_ch), 32'(k % 4));
    end

    // Idle cycle: no requests, result drains.
    cycle(4'b0000, 4'b0000, 4'b0000, 1'b1, seen);
    chk("idle_drain", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shared_seq_detect_sched.md
Name: shared_seq_detect_sched

Overview:
- Time-multiplexes one shared six-state w-sequence detector (states A..F, z asserted in E/F) across N independent input channels.
- Keeps a 3-bit state context per channel and picks one valid channel per cycle with a round-robin arbiter.
- For the granted channel it applies one detector step and returns the resulting z through a registered valid/ready output.
- Sits between N serial bit sources and a single result consumer.

Parameters:
- N, 4, number of channels (2..16)
- CH_W, $clog2(N), width of channel index

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  N  channel i offers bit in_w[i]
- in_w  input  N  per-channel w bit
- in_ready  output  N  one-hot grant; combinational from in_valid, ch_clear, pointer, output stall
- ch_clear  input  N  force channel i context to A at next edge
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts result
- out_ch  output  CH_W  channel of result
- out_z  output  1  z of that channel's post-step state
- ctx_z  output  N  registered per-channel Moore z (context==E or F)

Behaviour:
- Reset (sync, active-high): all contexts=A, ptr=0, out_valid=0, out_ch=0, out_z=0, ctx_z=0. Reset overrides all inputs in the same cycle.
- Step function (ctx,w -> next):
  - A: w?B:A
  - B: w?C:D
  - C: w?E:D
  - D: w?F:A
  - E: w?E:D
  - F: w?C:D
  - Codes 6,7 -> A (recovery, regardless of w).
- z(s) = (s==E)||(s==F).
- Eligibility: elig[i] = in_valid[i] & ~ch_clear[i].
- Stall: stall = out_valid & ~out_ready. When stall=1, in_ready=0.
- Grant:
  - When stall=0 and any elig bit is set, grant the first eligible channel scanning ptr, ptr+1, ... mod N.
  - in_ready is one-hot on the granted channel, otherwise all zero.
  - A transfer occurs when in_ready[g]=1 (in_valid implied).
- On transfer at edge:
  - ctx[g] <= step(ctx[g], in_w[g]).
  - out_valid<=1, out_ch<=g, out_z<=z(step(...)).
  - ptr <= (g+1) mod N.
  - Latency: input handshake to result visible = 1 cycle.
- No transfer:
  - If out_ready=1, out_valid<=0; out_ch/out_z hold.
  - If stall, out registers hold; ptr holds.
- Output register holds one result.
  - New transfer allowed in the same cycle the old result is accepted, giving full throughput of 1 step/cycle.
- ch_clear[i]: ctx[i]<=A at next edge. Never concurrent with a grant to i, since clear blocks eligibility. Other channels unaffected. An already-registered result for i is not retracted.
- ctx_z[i] = z(ctx[i]), registered via ctx. Updates the cycle after a step or clear.
- Multiple ch_clear bits may be set simultaneously.
- No valid channels: no grant, ptr holds.

Decomposition:
- Package seq_det_pkg holds:
  - typedef enum logic[2:0] state_t {A=0,B=1,C=2,D=3,E=4,F=5}
  - function step(state_t, logic w) returning state_t
  - function zout(state_t)
- Sub-module rr_arbiter (parameter N): inputs req[N], en, ptr; outputs gnt one-hot, gnt_idx, any.
- The top module holds the context array, ptr and output register.

Test Plan:
- Single channel 0, N=4, w stream 1,1,1,0,1: out_z sequence 0,0,1,0,1 after states B,C,E,D,F; ctx_z[0] ends 1.
- All four channels valid every cycle, out_ready=1: grants in order 0,1,2,3,0,... one per cycle. Each channel advances once per 4 cycles; out_ch follows grant with 1-cycle lag.
- Stall: out_valid=1, out_ready=0 for 3 cycles with channels valid: in_ready=0, out_ch/out_z held, contexts unchanged. On release, a grant occurs the same cycle, from ptr unchanged.
- Clear: drive channel 2 to E (w=1,1,1), then ch_clear[2]=1 with in_valid[2]=1. Channel 2 is not granted, ctx goes to A, ctx_z[2]=0, and a following w=1 yields out_z=0 (state B).
- Reset mid-stream with out_valid=1 and contexts in E/F: next cycle out_valid=0, ctx_z=0, ptr=0, and the first grant goes to the lowest valid channel.
- Fairness with requesters 1 and 3 only: grants alternate 1,3,1,3; ptr wraps from 3 to 0 correctly.
